// File: rtl/cordic_batch_sequencer_if.sv
// rtl/cordic_batch_sequencer_if.sv - begin/ready/ack handshake between the batch sequencer and a CORDIC core
interface cordic_batch_sequencer_if #(
  parameter int W = 32
);
  logic         beg_fsm_cordic;
  logic         ack_cordic;
  logic         operation;
  logic [W-1:0] data_in;
  logic [1:0]   shift_region_flag;
  logic [1:0]   r_mode;
  logic         ready_cordic;
  logic [W-1:0] data_output;
  logic         overflow_flag;
  logic         underflow_flag;

  modport master (
    output beg_fsm_cordic, ack_cordic, operation, data_in, shift_region_flag, r_mode,
    input  ready_cordic, data_output, overflow_flag, underflow_flag
  );

  modport slave (
    input  beg_fsm_cordic, ack_cordic, operation, data_in, shift_region_flag, r_mode,
    output ready_cordic, data_output, overflow_flag, underflow_flag
  );
endinterface

// File: rtl/cordic_batch_sequencer.sv
// rtl/cordic_batch_sequencer.sv - runs a table of angles through one CORDIC core and collects results/status
module cordic_batch_sequencer #(
  parameter int W          = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [1:0]              op_mode,
  input  logic [DEPTH_LOG2:0]     count,
  input  logic [1:0]              region_in,
  input  logic [1:0]              rmode_in,
  input  logic                    wr_en,
  input  logic [DEPTH_LOG2-1:0]   wr_addr,
  input  logic [W-1:0]            wr_data,
  input  logic [DEPTH_LOG2:0]     rd_addr,
  output logic [W-1:0]            rd_data,
  cordic_batch_sequencer_if.master core,
  output logic                    busy,
  output logic                    done,
  output logic                    err_timeout,
  output logic                    aborted,
  output logic [DEPTH_LOG2+1:0]   ovf_cnt,
  output logic [DEPTH_LOG2+1:0]   unf_cnt,
  output logic [DEPTH_LOG2+1:0]   res_cnt
);
  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int CW  = DEPTH_LOG2 + 2;
  localparam int IW  = DEPTH_LOG2 + 1;
  localparam logic [IW-1:0]  IDX_ONE = IW'(1);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);
  localparam logic [WDW-1:0] WDG_ONE = WDW'(1);
  localparam logic [WDW-1:0] WDG_MAX = WDW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, FETCH, LAUNCH, WAIT, ACK, NEXT, DONE} state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d, cnt_q, cnt_d;
  logic           dual_q, dual_d, sin_q, sin_d, op_q, op_d;
  logic [1:0]     region_q, region_d, rmode_q, rmode_d;
  logic [W-1:0]   data_in_q, data_in_d;
  logic           beg_q, beg_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           abort_seen_q, abort_seen_d, err_q, err_d, aborted_q, aborted_d;
  logic [CW-1:0]  ovf_q, ovf_d, unf_q, unf_d, res_q, res_d;
  logic [W-1:0]   tbl_rd_q, rd_data_q;
  logic           res_we;
  logic [IW-1:0]  res_addr;

  logic [W-1:0] tbl_mem [2**DEPTH_LOG2];
  logic [W-1:0] res_mem [2**IW];

  // Dual mode interleaves cos/sin so the two results of one angle sit side by side.
  assign res_addr = dual_q ? {idx_q[DEPTH_LOG2-1:0], op_q} : idx_q;

  always_ff @(posedge clk) begin
    if (wr_en && state_q == IDLE) tbl_mem[wr_addr] <= wr_data;
    if (state_q == FETCH) tbl_rd_q <= tbl_mem[idx_q[DEPTH_LOG2-1:0]];
    if (res_we) res_mem[res_addr] <= core.data_output;
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    dual_d       = dual_q;
    sin_d        = sin_q;
    op_d         = op_q;
    region_d     = region_q;
    rmode_d      = rmode_q;
    data_in_d    = data_in_q;
    beg_d        = 1'b0;
    wdog_d       = wdog_q;
    abort_seen_d = abort_seen_q | (abort & (state_q != IDLE));
    err_d        = err_q;
    aborted_d    = aborted_q;
    ovf_d        = ovf_q;
    unf_d        = unf_q;
    res_d        = res_q;
    res_we       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            idx_d        = '0;
            cnt_d        = count;
            dual_d       = op_mode[1];
            sin_d        = (op_mode == 2'b01);
            op_d         = (op_mode == 2'b01);
            region_d     = region_in;
            rmode_d      = rmode_in;
            abort_seen_d = 1'b0;
            err_d        = 1'b0;
            aborted_d    = 1'b0;
            ovf_d        = '0;
            unf_d        = '0;
            res_d        = '0;
            state_d      = FETCH;
          end else begin
            state_d = DONE;
          end
        end
      end
      FETCH: state_d = LAUNCH;
      LAUNCH: begin
        data_in_d    = tbl_rd_q;
        beg_d        = 1'b1;
        wdog_d       = '0;
        abort_seen_d = abort;
        state_d      = WAIT;
      end
      WAIT: begin
        if (core.ready_cordic) begin
          res_we  = 1'b1;
          ovf_d   = ovf_q + {{(CW-1){1'b0}}, core.overflow_flag};
          unf_d   = unf_q + {{(CW-1){1'b0}}, core.underflow_flag};
          res_d   = res_q + CNT_ONE;
          state_d = ACK;
        end else if (wdog_q == WDG_MAX) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wdog_d = wdog_q + WDG_ONE;
        end
      end
      ACK: if (!core.ready_cordic) state_d = NEXT;
      NEXT: begin
        if (dual_q && !op_q) begin
          op_d    = 1'b1;
          state_d = LAUNCH;
        end else if (abort_seen_q) begin
          aborted_d = 1'b1;
          state_d   = DONE;
        end else if (idx_q + IDX_ONE == cnt_q) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          op_d    = sin_q;
          state_d = FETCH;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      dual_q       <= 1'b0;
      sin_q        <= 1'b0;
      op_q         <= 1'b0;
      region_q     <= 2'b00;
      rmode_q      <= 2'b00;
      data_in_q    <= '0;
      beg_q        <= 1'b0;
      wdog_q       <= '0;
      abort_seen_q <= 1'b0;
      err_q        <= 1'b0;
      aborted_q    <= 1'b0;
      ovf_q        <= '0;
      unf_q        <= '0;
      res_q        <= '0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      dual_q       <= dual_d;
      sin_q        <= sin_d;
      op_q         <= op_d;
      region_q     <= region_d;
      rmode_q      <= rmode_d;
      data_in_q    <= data_in_d;
      beg_q        <= beg_d;
      wdog_q       <= wdog_d;
      abort_seen_q <= abort_seen_d;
      err_q        <= err_d;
      aborted_q    <= aborted_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      res_q        <= res_d;
      rd_data_q    <= res_mem[rd_addr];
    end
  end

  assign core.beg_fsm_cordic    = beg_q;
  assign core.ack_cordic        = (state_q == ACK);
  assign core.operation         = op_q;
  assign core.data_in           = data_in_q;
  assign core.shift_region_flag = region_q;
  assign core.r_mode            = rmode_q;

  assign rd_data     = rd_data_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign err_timeout = err_q;
  assign aborted     = aborted_q;
  assign ovf_cnt     = ovf_q;
  assign unf_cnt     = unf_q;
  assign res_cnt     = res_q;
endmodule

// File: tb/tb_cordic_batch_sequencer.sv
// tb/tb_cordic_batch_sequencer.sv - scoreboard bench for cordic_batch_sequencer with a behavioural core
module tb_cordic_batch_sequencer;
  localparam int W  = 32;
  localparam int DL = 10;
  localparam int TO = 255;
  localparam int CW = DL + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    op_mode = 2'b00;
  logic [DL:0]   count = '0;
  logic [1:0]    region_in = 2'b01;
  logic [1:0]    rmode_in = 2'b10;
  logic          wr_en = 1'b0;
  logic [DL-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic [DL:0]   rd_addr = '0;
  logic [W-1:0]  rd_data;
  logic          busy, done, err_timeout, aborted;
  logic [CW-1:0] ovf_cnt, unf_cnt, res_cnt;

  cordic_batch_sequencer_if #(.W(W)) cif ();

  cordic_batch_sequencer #(.W(W), .DEPTH_LOG2(DL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .op_mode(op_mode), .count(count),
    .region_in(region_in), .rmode_in(rmode_in), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .core(cif), .busy(busy),
    .done(done), .err_timeout(err_timeout), .aborted(aborted), .ovf_cnt(ovf_cnt),
    .unf_cnt(unf_cnt), .res_cnt(res_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [W:0]      beg_exp  [$];
  int              ack_exp  [$];
  logic [3*CW+1:0] done_exp [$];
  logic [W-1:0]    rd_exp   [$];
  logic [W-1:0]    tbl [1024];
  int   done_seen = 0;
  int   nd = 0;
  logic rd_req = 1'b0;
  logic rd_vld = 1'b0;
  int   core_lat = 3;
  int   core_hold = 0;
  int   core_idx = 0;
  logic core_mute = 1'b0;
  logic [7:0] ovf_mask = 8'h00;
  logic [7:0] unf_mask = 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic op);
    if (a == 32'h3F25514D) return op ? 32'h3F1A9B66 : 32'h3F4C0EBF;
    if (a == 32'h00000000) return op ? 32'h00000000 : 32'h3F800000;
    return a ^ (op ? 32'h55555555 : 32'hAAAAAAAA);
  endfunction

  // Behavioural CORDIC core: fixed latency, ready held for 1+core_hold cycles.
  initial begin : core_model
    logic [W-1:0] a;
    logic         o;
    cif.ready_cordic   = 1'b0;
    cif.data_output    = '0;
    cif.overflow_flag  = 1'b0;
    cif.underflow_flag = 1'b0;
    forever begin
      @(negedge clk);
      if (cif.beg_fsm_cordic && !core_mute && !rst) begin
        a = cif.data_in;
        o = cif.operation;
        repeat (core_lat) @(negedge clk);
        cif.data_output    = model(a, o);
        cif.overflow_flag  = ovf_mask[core_idx % 8];
        cif.underflow_flag = unf_mask[core_idx % 8];
        cif.ready_cordic   = 1'b1;
        repeat (1 + core_hold) @(negedge clk);
        cif.ready_cordic   = 1'b0;
        cif.overflow_flag  = 1'b0;
        cif.underflow_flag = 1'b0;
        core_idx++;
      end
    end
  end

  always @(posedge clk) rd_vld <= rd_req;

  initial begin : monitor
    int ack_run;
    logic [W:0]      be;
    logic [3*CW+1:0] de;
    logic [W-1:0]    re;
    int              ae;
    ack_run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ack_run = 0;
      end else begin
        if (cif.beg_fsm_cordic) begin
          check("beg_expected", beg_exp.size() > 0, 1'b1);
          if (beg_exp.size() > 0) begin
            be = beg_exp.pop_front();
            check("beg_operation", cif.operation, be[W]);
            check("beg_data_in", cif.data_in, be[W-1:0]);
            check("beg_region_rmode", {cif.shift_region_flag, cif.r_mode}, {region_in, rmode_in});
          end
        end
        if (cif.ack_cordic) begin
          ack_run++;
        end else if (ack_run > 0) begin
          check("ack_expected", ack_exp.size() > 0, 1'b1);
          if (ack_exp.size() > 0) begin
            ae = ack_exp.pop_front();
            check("ack_length", ack_run, ae);
          end
          ack_run = 0;
        end
        if (done) begin
          done_seen++;
          check("done_expected", done_exp.size() > 0, 1'b1);
          if (done_exp.size() > 0) begin
            de = done_exp.pop_front();
            check("done_status", {res_cnt, ovf_cnt, unf_cnt, err_timeout, aborted}, de);
          end
        end
        if (rd_vld) begin
          check("rd_expected", rd_exp.size() > 0, 1'b1);
          if (rd_exp.size() > 0) begin
            re = rd_exp.pop_front();
            check("rd_data", rd_data, re);
          end
        end
      end
    end
  end

  task automatic pulse_start(input logic [1:0] m, input int c);
    @(negedge clk);
    op_mode = m;
    count   = c[DL:0];
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic exp_op(input int i, input logic op, input int hold);
    beg_exp.push_back({op, tbl[i]});
    if (hold >= 0) ack_exp.push_back(hold + 1);
  endtask

  task automatic exp_done(input int r, input int o, input int u, input logic e, input logic a);
    done_exp.push_back({r[CW-1:0], o[CW-1:0], u[CW-1:0], e, a});
    nd++;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (done_seen >= nd) break;
      @(negedge clk);
    end
    check("done_reached", done_seen, nd);
  endtask

  task automatic read_res(input int a, input logic [W-1:0] e);
    @(negedge clk);
    rd_addr = a[DL:0];
    rd_req  = 1'b1;
    rd_exp.push_back(e);
    @(negedge clk);
    rd_req  = 1'b0;
  endtask

  initial begin : stimulus
    int n;
    int nb;
    logic prev;
    for (int i = 0; i < 1024; i++) tbl[i] = 32'h3E000000 + i * 32'h00000111;
    tbl[0] = 32'h3F25514D;
    tbl[1] = 32'h00000000;

    repeat (3) @(negedge clk);
    check("rst_busy_done", {busy, done}, 2'b00);
    check("rst_beg_ack", {cif.beg_fsm_cordic, cif.ack_cordic, cif.operation}, 3'b000);
    check("rst_data_in", cif.data_in, 32'h0);
    check("rst_status", {res_cnt, ovf_cnt, unf_cnt, err_timeout, aborted}, '0);
    check("rst_core_ctrl", {cif.shift_region_flag, cif.r_mode}, 4'h0);
    rst = 1'b0;

    // Zero-length batch goes straight to DONE.
    exp_done(0, 0, 0, 1'b0, 1'b0);
    pulse_start(2'b00, 0);
    wait_done(20);

    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = i[DL-1:0];
      wr_data = tbl[i];
    end
    @(negedge clk);
    wr_en = 1'b0;

    // Sin, single angle, slow core.
    core_lat = 20;
    exp_op(0, 1'b1, 0);
    exp_done(1, 0, 0, 1'b0, 1'b0);
    pulse_start(2'b01, 1);
    @(negedge clk);
    check("beg_cycle_k1", cif.beg_fsm_cordic, 1'b0);
    @(negedge clk);
    check("beg_cycle_k2", cif.beg_fsm_cordic, 1'b1);
    prev = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (prev && !cif.ack_cordic) break;
      prev = cif.ack_cordic;
    end
    check("ack_fell", prev, 1'b1);
    check("done_not_early", done, 1'b0);
    @(negedge clk);
    check("done_after_ack", done, 1'b1);
    wait_done(20);
    read_res(0, 32'h3F1A9B66);
    core_lat = 3;

    // Dual mode, two angles.
    exp_op(0, 1'b0, 0); exp_op(0, 1'b1, 0); exp_op(1, 1'b0, 0); exp_op(1, 1'b1, 0);
    exp_done(4, 0, 0, 1'b0, 1'b0);
    pulse_start(2'b10, 2);
    wait_done(200);
    read_res(0, 32'h3F4C0EBF);
    read_res(1, 32'h3F1A9B66);
    read_res(2, 32'h3F800000);
    read_res(3, 32'h00000000);

    // Core keeps ready high three extra cycles.
    core_hold = 3;
    exp_op(0, 1'b0, 3);
    exp_done(1, 0, 0, 1'b0, 1'b0);
    pulse_start(2'b00, 1);
    wait_done(100);
    read_res(0, 32'h3F4C0EBF);
    core_hold = 0;

    // Core never answers: watchdog.
    core_mute = 1'b1;
    exp_op(0, 1'b1, -1);
    exp_done(0, 0, 0, 1'b1, 1'b0);
    pulse_start(2'b01, 1);
    for (int i = 0; i < 10; i++) begin
      if (cif.beg_fsm_cordic) break;
      @(negedge clk);
    end
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    check("timeout_latency", n, 256);
    wait_done(10);
    core_mute = 1'b0;

    // Full-depth batch, abort during the fifth WAIT; start and table writes while busy are ignored.
    for (int i = 0; i < 5; i++) exp_op(i, 1'b0, 0);
    exp_done(5, 0, 0, 1'b0, 1'b1);
    pulse_start(2'b00, 1024);
    nb = 0;
    for (int i = 0; i < 500 && nb < 5; i++) begin
      @(negedge clk);
      start   = (i == 1);
      wr_en   = (i == 2);
      wr_addr = '0;
      wr_data = 32'hDEADBEEF;
      if (cif.beg_fsm_cordic) nb++;
    end
    start = 1'b0;
    wr_en = 1'b0;
    check("abort_begs", nb, 5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(200);
    for (int i = 0; i < 5; i++) read_res(i, model(tbl[i], 1'b0));

    // op_mode 11 behaves as dual; table[0] must be untouched by the busy write.
    exp_op(0, 1'b0, 0); exp_op(0, 1'b1, 0);
    exp_done(2, 0, 0, 1'b0, 1'b0);
    pulse_start(2'b11, 1);
    wait_done(100);
    read_res(0, 32'h3F4C0EBF);
    read_res(1, 32'h3F1A9B66);

    // Overflow on results 2, 5, 7 and underflow on result 1.
    core_idx = 0;
    ovf_mask = 8'b1010_0100;
    unf_mask = 8'b0000_0010;
    for (int i = 0; i < 8; i++) exp_op(i, 1'b0, 0);
    exp_done(8, 3, 1, 1'b0, 1'b0);
    pulse_start(2'b00, 8);
    wait_done(300);
    read_res(2, model(tbl[2], 1'b0));
    read_res(7, model(tbl[7], 1'b0));
    ovf_mask = 8'h00;
    unf_mask = 8'h00;

    // Reset in the middle of the second WAIT.
    core_lat = 10;
    core_idx = 0;
    ovf_mask = 8'h01;
    exp_op(0, 1'b1, 0);
    exp_op(1, 1'b1, -1);
    pulse_start(2'b01, 2);
    nb = 0;
    for (int i = 0; i < 200 && nb < 2; i++) begin
      @(negedge clk);
      if (cif.beg_fsm_cordic) nb++;
    end
    check("rst_test_begs", nb, 2);
    @(negedge clk);
    check("pre_rst_counts", {busy, res_cnt, ovf_cnt}, {1'b1, 12'd1, 12'd1});
    rst = 1'b1;
    @(negedge clk);
    check("midrst_beg_ack_busy", {cif.beg_fsm_cordic, cif.ack_cordic, busy, done}, 4'b0000);
    check("midrst_counts", {res_cnt, ovf_cnt, unf_cnt}, '0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("no_done_after_rst", done_seen, nd);
    ovf_mask = 8'h00;
    core_lat = 3;

    repeat (5) @(negedge clk);
    check("beg_queue_empty", beg_exp.size(), 0);
    check("ack_queue_empty", ack_exp.size(), 0);
    check("done_queue_empty", done_exp.size(), 0);
    check("rd_queue_empty", rd_exp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : global_guard
    #500000;
    $display("FAIL global_timeout: got no end of run, expected finish before 500000 ns");
    $fatal(1, "simulation did not terminate");
  end
endmodule

// File: doc/cordic_batch_sequencer.md
Name: cordic_batch_sequencer

Overview:
Synthesizable batch controller that drives a CORDIC sine/cosine core over the begin/ready/ack handshake. It holds a host-loaded table of input angles and issues one core operation per angle, or two per angle in dual mode. It stores each core result in a result memory and keeps per-batch status (overflow/underflow counts, timeout, abort). It sits between a host/BIST interface and one CORDIC_Arch2 instance and is parametrised over word width, table depth and watchdog length.

Parameters:
W, 32, data word width (32 single, 64 double)
DEPTH_LOG2, 10, log2 of angle-table entries (1024 default)
TIMEOUT, 255, max cycles in WAIT before watchdog error; counter width clog2(TIMEOUT+1)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle batch start pulse
abort  in  1  graceful-stop request
op_mode  in  2  00 cos, 01 sin, 10 both (cos then sin), 11 treated as 10
count  in  DEPTH_LOG2+1  angles to process, 0..2**DEPTH_LOG2
region_in  in  2  shift_region_flag applied to every operation
rmode_in  in  2  rounding mode passed to core
wr_en  in  1  angle-table write strobe
wr_addr  in  DEPTH_LOG2  angle-table write address
wr_data  in  W  angle (radians, IEEE-754)
rd_addr  in  DEPTH_LOG2+1  result-memory read address
rd_data  out  W  result word, 1-cycle read latency
beg_fsm_cordic  out  1  core start
ack_cordic  out  1  core result acknowledge
operation  out  1  1 sin, 0 cos
data_in  out  W  angle to core
shift_region_flag  out  2  to core
r_mode  out  2  to core
ready_cordic  in  1  core result valid
data_output  in  W  core result
overflow_flag  in  1  core overflow
underflow_flag  in  1  core underflow
busy  out  1  FSM not in IDLE
done  out  1  one-cycle batch-complete pulse
err_timeout  out  1  sticky until next accepted start
aborted  out  1  sticky until next accepted start
ovf_cnt  out  DEPTH_LOG2+2  results with overflow_flag
unf_cnt  out  DEPTH_LOG2+2  results with underflow_flag
res_cnt  out  DEPTH_LOG2+2  results written this batch

Behaviour:
- Reset: all outputs 0, including data_in and the status counters; state IDLE. Memory contents are not reset. Reset mid-batch drops beg and ack immediately; no done pulse.
- States: IDLE, FETCH, LAUNCH, WAIT, ACK, NEXT, DONE.
- IDLE, start=1 and count>0:
  - clear counters and sticky flags; latch op_mode, count, region_in, rmode_in; idx=0; operation = (op_mode==01).
  - go to FETCH.
- IDLE, start=1 and count==0: go to DONE.
- start is ignored in every state except IDLE. wr_en is ignored while busy.
- FETCH: synchronous table read at idx; go to LAUNCH.
- LAUNCH:
  - data_in registered from the table read.
  - beg_fsm_cordic=1 for exactly this one cycle; go to WAIT with the watchdog cleared.
  - Sampling: start at edge k gives beg high in cycle k+2.
- WAIT:
  - ready_cordic=1: write data_output to the result memory, add overflow_flag/underflow_flag into ovf_cnt/unf_cnt, res_cnt+1, go to ACK.
  - Result address: idx in single mode; 2*idx+operation in dual mode.
  - Watchdog reaches TIMEOUT without ready: set err_timeout, go to DONE.
- ACK: ack_cordic=1 every cycle in ACK. Leave to NEXT on the first cycle ready_cordic==0; ack is 0 in NEXT.
- NEXT, in priority order:
  - dual mode and operation==0: set operation=1, go to LAUNCH (same data_in, no refetch).
  - else abort was seen since the last LAUNCH (abort is latched): set aborted, go to DONE.
  - else idx+1==count: go to DONE.
  - else idx+1, operation reset to the mode default, go to FETCH.
- DONE: done=1 for one cycle, then IDLE.
- Abort never cuts a core operation in flight. Abort in IDLE has no effect.
- Data is written to the result memory only in WAIT. A host read of an address being written in the same cycle returns the old data.

Test Plan:
- Sin mode, count=1, table[0]=32'h3F25514D, core model replies 32'h3F1A9B66 after 20 cycles -> beg high in cycle k+2; result[0]=32'h3F1A9B66; res_cnt=1; done 1 cycle after ack drops.
- Dual mode, count=2, table={32'h3F25514D, 32'h00000000} -> 4 beg pulses, with operation = 0,1,0,1; result[0..3] = cos0, sin0, cos1, sin1; res_cnt=4.
- Core holds ready_cordic high for 3 cycles after its first high cycle -> ack high 4 cycles; exactly one result write.
- Core never asserts ready, TIMEOUT=255 -> err_timeout=1 on cycle 256 of WAIT; done pulse; res_cnt=0.
- count=1024, abort pulsed during the 5th WAIT -> 5 results written, aborted=1, done pulse; start during busy ignored.
- Model sets overflow_flag on 3 of 8 results -> ovf_cnt=3. Then rst asserted mid-WAIT -> next cycle beg=0, ack=0, busy=0, counters=0.
